// File: rtl/sipo_deser.sv
// sipo_deser: serial-in, parallel-out deserializer feeding a parallel-load
// register. Collects WIDTH qualified serial bits into a word, then presents
// the word on data_out together with a one-cycle load pulse.
//
// Optional feature macro: PARITY_CHK_EN
//   defined   : a trailing even-parity bit follows every word; a word is only
//               delivered when parity matches, otherwise parity_err pulses.
//   undefined : no parity bit, parity_err is tied to 0.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         ser_in,
  input  logic                         ser_valid,
  output logic [WIDTH-1:0]             data_out,
  output logic                         load,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
`ifdef PARITY_CHK_EN
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
`endif

`ifdef PARITY_CHK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    cnt_q;
  logic             load_q;
  logic             busy_q;
`ifdef PARITY_CHK_EN
  logic             perr_q;
  logic             parity_ok;
`endif

  // Shift register contents once the current ser_in bit is taken in.
  always_comb begin
    shift_d = shift_q;
    if (MSB_FIRST) begin
      shift_d = {shift_q[WIDTH-2:0], ser_in};
    end else begin
      shift_d = {ser_in, shift_q[WIDTH-1:1]};
    end
  end

`ifdef PARITY_CHK_EN
  // Even parity across the assembled data bits and the incoming parity bit.
  always_comb begin
    parity_ok = ~((^shift_q) ^ ser_in);
  end
`endif

  // Control FSM, bit counter, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PARITY_CHK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      // Pulses default low; they are only raised on a completion edge.
      load_q <= 1'b0;
`ifdef PARITY_CHK_EN
      perr_q <= 1'b0;
`endif
      if (clear) begin
        // Abort: drop the partial word, keep the last delivered word.
        state_q <= IDLE;
        shift_q <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else if (ser_valid) begin
        case (state_q)
          IDLE, SHIFT: begin
            if (cnt_q == LAST_IDX) begin
`ifdef PARITY_CHK_EN
              // Last data bit: wait for the parity bit before delivering.
              shift_q <= shift_d;
              cnt_q   <= FULL_CNT;
              state_q <= PARITY;
              busy_q  <= 1'b1;
`else
              // Last data bit: deliver the word in the same edge.
              data_q  <= shift_d;
              load_q  <= 1'b1;
              shift_q <= '0;
              cnt_q   <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
`endif
            end else begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + CW'(1);
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end
`ifdef PARITY_CHK_EN
          PARITY: begin
            if (parity_ok) begin
              data_q <= shift_q;
              load_q <= 1'b1;
            end else begin
              perr_q <= 1'b1;
            end
            shift_q <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
`endif
          default: begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out = data_q;
  assign load     = load_q;
  assign busy     = busy_q;
  assign bit_cnt  = cnt_q;
`ifdef PARITY_CHK_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: scoreboard bench for sipo_deser. Instance A is MSB-first,
// instance B is LSB-first; both are 8 bits wide.
module tb_sipo_deser;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
`ifdef PARITY_CHK_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WLEN = W + PAR;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_a, ser_a, vld_a;
  logic          clr_b, ser_b, vld_b;
  logic [W-1:0]  data_a, data_b;
  logic          load_a, load_b, busy_a, busy_b, perr_a, perr_b;
  logic [CW-1:0] cnt_a, cnt_b;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [W-1:0]  sb_a[$];
  logic [W-1:0]  sb_b[$];
  int            cyc = 0;
  int            last_load_a = -1;
  bit            spacing_on = 1'b0;
  logic          perr_exp = 1'b0;
  logic [W-1:0]  pipo;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset(rst_n), .clear(clr_a), .ser_in(ser_a), .ser_valid(vld_a),
    .data_out(data_a), .load(load_a), .busy(busy_a), .bit_cnt(cnt_a),
    .parity_err(perr_a)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset(rst_n), .clear(clr_b), .ser_in(ser_b), .ser_valid(vld_b),
    .data_out(data_b), .load(load_b), .busy(busy_b), .bit_cnt(cnt_b),
    .parity_err(perr_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream parallel-load register fed by instance A.
  always @(posedge clk) begin
    if (!rst_n) pipo <= '0;
    else if (load_a) pipo <= data_a;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic b);
    if (sel) begin vld_b = v; ser_b = b; end
    else     begin vld_a = v; ser_a = b; end
  endtask

  // Sends one word on instance sel (0=A MSB-first, 1=B LSB-first),
  // checking bit_cnt/busy after every edge.
  task automatic send_word(input bit sel, input logic [W-1:0] w, input bit gap,
                           input bit bad_par, input bit keep_valid);
    logic b;
    int   exp_cnt;
    string s;
    s = sel ? "b" : "a";
    if (!bad_par) begin
      if (sel) sb_b.push_back(w);
      else     sb_a.push_back(w);
    end
    for (int i = 0; i < W; i++) begin
      b = sel ? w[i] : w[W-1-i];
      drive(sel, 1'b1, b);
      @(posedge clk); #1;
      exp_cnt = (i == W-1) ? (PAR ? W : 0) : i + 1;
      check({"cnt_", s}, 32'(sel ? cnt_b : cnt_a), 32'(exp_cnt));
      check({"busy_", s}, 32'(sel ? busy_b : busy_a), 32'(exp_cnt != 0));
      if (gap) begin
        drive(sel, 1'b0, 1'b0);
        @(posedge clk); #1;
        check({"cnt_gap_", s}, 32'(sel ? cnt_b : cnt_a), 32'(exp_cnt));
      end
    end
`ifdef PARITY_CHK_EN
    drive(sel, 1'b1, bad_par ? ~(^w) : (^w));
    @(posedge clk); #1;
    perr_exp = bad_par;
    check({"perr_", s}, 32'(sel ? perr_b : perr_a), 32'(bad_par));
    check({"cnt_par_", s}, 32'(sel ? cnt_b : cnt_a), 32'd0);
    if (bad_par) begin
      drive(sel, 1'b0, 1'b0);
      @(posedge clk); #1;
      perr_exp = 1'b0;
      check({"perr_end_", s}, 32'(sel ? perr_b : perr_a), 32'd0);
    end
`endif
    if (!keep_valid) drive(sel, 1'b0, 1'b0);
  endtask

  // Scoreboard: every load pulse must match the oldest queued word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_a) begin
        if (sb_a.size() == 0) check("load_a_unexpected", 32'd1, 32'd0);
        else check("data_a", 32'(data_a), 32'(sb_a.pop_front()));
        if (spacing_on && last_load_a >= 0)
          check("load_spacing", 32'(cyc - last_load_a), 32'(WLEN));
        last_load_a = cyc;
      end
      if (load_b) begin
        if (sb_b.size() == 0) check("load_b_unexpected", 32'd1, 32'd0);
        else check("data_b", 32'(data_b), 32'(sb_b.pop_front()));
      end
      if (perr_a !== perr_exp) check("perr_a_mon", 32'(perr_a), 32'(perr_exp));
      if (perr_b !== 1'b0) check("perr_b_mon", 32'(perr_b), 32'd0);
    end
  end

  initial begin
    rst_n = 1'b0;
    clr_a = 1'b0; vld_a = 1'b1; ser_a = 1'b1;
    clr_b = 1'b0; vld_b = 1'b1; ser_b = 1'b1;

    // Reset held two edges with valid data present.
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_a", 32'(data_a), 32'h00);
    check("rst_load_a", 32'(load_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_cnt_a",  32'(cnt_a),  32'd0);
    check("rst_data_b", 32'(data_b), 32'h00);
    check("rst_cnt_b",  32'(cnt_b),  32'd0);
    check("rst_perr_a", 32'(perr_a), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0);

    // 0xAA MSB-first; first edge after release takes the first bit.
    send_word(1'b0, 8'hAA, 1'b0, 1'b0, 1'b0);
    check("load_pulse", 32'(load_a), 32'd1);
    check("data_latency", 32'(data_a), 32'hAA);
    @(posedge clk); #1;
    check("load_drop", 32'(load_a), 32'd0);
    check("data_hold", 32'(data_a), 32'hAA);
    check("pipo", 32'(pipo), 32'hAA);

    // 0x55 LSB-first with alternate-cycle gaps on instance B.
    send_word(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check("gap_data_b", 32'(data_b), 32'h55);
    check("gap_load_b", 32'(load_b), 32'd0);
    send_word(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);

    // Back-to-back words with valid held high.
    repeat (2) @(posedge clk);
    #1;
    spacing_on  = 1'b1;
    last_load_a = -1;
    send_word(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
    send_word(1'b0, 8'h34, 1'b0, 1'b0, 1'b1);
    send_word(1'b0, 8'h56, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    spacing_on = 1'b0;
    check("btb_drained", 32'(sb_a.size()), 32'd0);

    // Clear after five bits of 0xFF, valid held during the clear cycle.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
    end
    check("pre_clr_cnt", 32'(cnt_a), 32'd5);
    clr_a = 1'b1;
    drive(1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    clr_a = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    check("clr_cnt", 32'(cnt_a), 32'd0);
    check("clr_busy", 32'(busy_a), 32'd0);
    check("clr_load", 32'(load_a), 32'd0);
    check("clr_data", 32'(data_a), 32'h56);
    send_word(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
    check("post_clr_data", 32'(data_a), 32'h0F);

    // Clear coinciding with the final data bit discards the word.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < W-1; i++) begin
      drive(1'b0, 1'b1, 1'(i & 1));
      @(posedge clk); #1;
    end
    clr_a = 1'b1;
    drive(1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    clr_a = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    check("clr_last_load", 32'(load_a), 32'd0);
    check("clr_last_data", 32'(data_a), 32'h0F);
    check("clr_last_cnt", 32'(cnt_a), 32'd0);

`ifdef PARITY_CHK_EN
    // Good parity delivers; bad parity keeps the previous word.
    send_word(1'b0, 8'hAA, 1'b0, 1'b0, 1'b0);
    check("par_ok_data", 32'(data_a), 32'hAA);
    send_word(1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
    check("par_bad_data", 32'(data_a), 32'hAA);
    check("par_bad_load", 32'(load_a), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_a_empty", 32'(sb_a.size()), 32'd0);
    check("sb_b_empty", 32'(sb_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
